// File: rtl/mips_alu_pkg.sv
// Shared EX-stage definitions: ALU op codes, mul/div op codes,
// and the mul/div sequencer state encoding.
package mips_alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CALC  = 2'b01,
    S_FIXUP = 2'b10,
    S_DONE  = 2'b11
  } md_state_e;

  function automatic logic md_is_div(md_op_e op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mul_div_sequencer_if.sv
// Request/result bundle between the EX stage and the
// iterative multiply/divide unit.
interface mul_div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, flush,
    output hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    input  hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/md_step_datapath.sv
// One iteration of the mul/div loop: shift-add multiply or
// restoring divide step, purely combinational.
module md_step_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   rem_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0]   rem_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Multiply keeps the multiplier in the low word and grows the
  // product from the top; divide shifts dividend bits into rem.
  always_comb begin
    acc_o   = acc_i;
    rem_o   = rem_i;
    sum     = '0;
    shifted = '0;
    trial   = '0;
    if (is_div) begin
      shifted = {rem_i, acc_i[WIDTH-1]};
      trial   = shifted - {1'b0, b_i};
      rem_o   = trial[WIDTH] ? shifted[WIDTH-1:0]
                             : trial[WIDTH-1:0];
      acc_o   = {acc_i[2*WIDTH-1:WIDTH],
                 acc_i[WIDTH-2:0], ~trial[WIDTH]};
    end else begin
      sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
            + (acc_i[0] ? {1'b0, b_i} : '0);
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; stalls the
// pipeline via busy and signals completion with a done pulse.
module mul_div_sequencer
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  mul_div_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               div_q, div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   step_rem;

  md_step_datapath #(.WIDTH(WIDTH)) u_step (
    .is_div (div_q),
    .acc_i  (acc_q),
    .rem_i  (rem_q),
    .b_i    (b_q),
    .acc_o  (step_acc),
    .rem_o  (step_rem)
  );

  md_op_e             op_in;
  logic               sgn;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod;

  assign op_in = md_op_e'(bus.op);
  assign sgn   = md_is_signed(op_in);
  assign a_neg = sgn & bus.src_a[WIDTH-1];
  assign b_neg = sgn & bus.src_b[WIDTH-1];
  assign mag_a = a_neg ? -bus.src_a : bus.src_a;
  assign mag_b = b_neg ? -bus.src_b : bus.src_b;

  // Next-state, datapath loading and HI/LO update decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    b_d       = b_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    prod      = neg_res_q ? -acc_q : acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.start && !bus.flush) begin
          div_d = md_is_div(op_in);
          if (md_is_div(op_in) && bus.src_b == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            dbz_d   = 1'b1;
          end else begin
            acc_d     = {{WIDTH{1'b0}}, mag_a};
            rem_d     = '0;
            b_d       = mag_b;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = '0;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        rem_d = step_rem;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        if (div_q) begin
          lo_d = neg_res_q ? -acc_q[WIDTH-1:0]
                           : acc_q[WIDTH-1:0];
          hi_d = neg_rem_q ? -rem_q : rem_q;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_q != S_IDLE && bus.flush) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State, iteration registers and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      b_q       <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      b_q       <= b_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
